// File: rtl/seg_display_arbiter_if.sv
// Producer-side handshake shared by the score (channel 0) and banner (channel 1)
// frame sources and the segment display arbiter.
interface seg_display_arbiter_if #(
    parameter int FRAME_BITS = 64
);
    logic                  req0;
    logic [FRAME_BITS-1:0] data0;
    logic                  ack0;
    logic                  req1;
    logic [FRAME_BITS-1:0] data1;
    logic                  ack1;
    logic                  hold1;
    logic                  busy;
    logic                  active_src;
    logic                  frame_done;

    modport master (
        output req0, data0, req1, data1, hold1,
        input  ack0, ack1, busy, active_src, frame_done
    );

    modport slave (
        input  req0, data0, req1, data1, hold1,
        output ack0, ack1, busy, active_src, frame_done
    );
endinterface

// File: rtl/seg_display_arbiter.sv
// Two-channel frame buffer, fixed-priority arbiter and MSB-first serialiser for
// the 8-digit serial segment display.
module seg_display_arbiter #(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    seg_display_arbiter_if.slave bus,
    output logic                 SEGCLK,
    output logic                 SEGCLR,
    output logic                 SEGDT,
    output logic                 SEGEN
);
    localparam int DW = $clog2(2 * CLK_DIV);
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] FULL_LAST = DW'(2 * CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_LOAD = 3'd2,
        ST_LO   = 3'd3,
        ST_HI   = 3'd4,
        ST_GAP  = 3'd5
    } state_t;

    state_t                state_r, state_s;
    logic [DW-1:0]         div_r, div_s;
    logic [BW-1:0]         bit_r, bit_s;
    logic [FRAME_BITS-1:0] buf0_r, buf1_r, shreg_r, shreg_s;
    logic                  pend0_r, pend0_s, pend1_r, pend1_s;
    logic                  ack0_r, ack0_s, ack1_r, ack1_s;
    logic                  busy_r, busy_s, src_r, src_s, done_r, done_s;
    logic                  segclk_r, segclk_s, segclr_r, segclr_s;
    logic                  segdt_r, segdt_s, segen_r;

    // Latest-wins frame buffers; a capture in the same cycle still sees the old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf0_r <= '0;
            buf1_r <= '0;
        end else begin
            if (bus.req0) buf0_r <= bus.data0;
            if (bus.req1) buf1_r <= bus.data1;
        end
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_INIT;
            div_r    <= '0;
            bit_r    <= '0;
            shreg_r  <= '0;
            pend0_r  <= 1'b0;
            pend1_r  <= 1'b0;
            ack0_r   <= 1'b0;
            ack1_r   <= 1'b0;
            busy_r   <= 1'b0;
            src_r    <= 1'b0;
            done_r   <= 1'b0;
            segclk_r <= 1'b0;
            segclr_r <= 1'b0;
            segdt_r  <= 1'b0;
            segen_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            div_r    <= div_s;
            bit_r    <= bit_s;
            shreg_r  <= shreg_s;
            pend0_r  <= pend0_s;
            pend1_r  <= pend1_s;
            ack0_r   <= ack0_s;
            ack1_r   <= ack1_s;
            busy_r   <= busy_s;
            src_r    <= src_s;
            done_r   <= done_s;
            segclk_r <= segclk_s;
            segclr_r <= segclr_s;
            segdt_r  <= segdt_s;
            segen_r  <= 1'b1;
        end
    end

    // Next-state logic: arbitration in IDLE, capture on the edge into LOAD.
    always_comb begin
        state_s  = state_r;
        div_s    = div_r + DW'(1);
        bit_s    = bit_r;
        shreg_s  = shreg_r;
        pend0_s  = pend0_r | bus.req0;
        pend1_s  = pend1_r | bus.req1;
        ack0_s   = 1'b0;
        ack1_s   = 1'b0;
        busy_s   = busy_r;
        src_s    = src_r;
        done_s   = 1'b0;
        segclr_s = segclr_r;
        case (state_r)
            ST_INIT: begin
                if (div_r == FULL_LAST) begin
                    state_s  = ST_IDLE;
                    div_s    = '0;
                    segclr_s = 1'b1;
                end else begin
                    state_s  = ST_INIT;
                end
            end
            ST_IDLE: begin
                div_s = '0;
                bit_s = '0;
                // A same-cycle request re-arms the pending flag for a follow-up frame.
                if (pend1_r) begin
                    state_s = ST_LOAD;
                    shreg_s = buf1_r;
                    pend1_s = bus.req1;
                    ack1_s  = 1'b1;
                    src_s   = 1'b1;
                    busy_s  = 1'b1;
                end else if (pend0_r && !bus.hold1) begin
                    state_s = ST_LOAD;
                    shreg_s = buf0_r;
                    pend0_s = bus.req0;
                    ack0_s  = 1'b1;
                    src_s   = 1'b0;
                    busy_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_s = ST_LO;
                div_s   = '0;
            end
            ST_LO: begin
                if (div_r == HALF_LAST) begin
                    state_s = ST_HI;
                    div_s   = '0;
                end else begin
                    state_s = ST_LO;
                end
            end
            ST_HI: begin
                if (div_r == HALF_LAST) begin
                    div_s   = '0;
                    shreg_s = {shreg_r[FRAME_BITS-2:0], 1'b0};
                    bit_s   = bit_r + BW'(1);
                    if (bit_r == BIT_LAST) begin
                        state_s = ST_GAP;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_LO;
                    end
                end else begin
                    state_s = ST_HI;
                end
            end
            ST_GAP: begin
                if (div_r == FULL_LAST) begin
                    state_s = ST_IDLE;
                    div_s   = '0;
                    busy_s  = 1'b0;
                end else begin
                    state_s = ST_GAP;
                end
            end
            default: begin
                state_s = ST_INIT;
                div_s   = '0;
            end
        endcase
        segclk_s = (state_s == ST_HI) ? 1'b1 : 1'b0;
        segdt_s  = ((state_s == ST_LO) || (state_s == ST_HI)) ? shreg_s[FRAME_BITS-1] : 1'b0;
    end

    assign bus.ack0       = ack0_r;
    assign bus.ack1       = ack1_r;
    assign bus.busy       = busy_r;
    assign bus.active_src = src_r;
    assign bus.frame_done = done_r;
    assign SEGCLK         = segclk_r;
    assign SEGCLR         = segclr_r;
    assign SEGDT          = segdt_r;
    assign SEGEN          = segen_r;
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench: transaction-level reference model, frame decoder on the
// serial pins, table-driven directed frames and hand-written corner sequences.
module tb_seg_display_arbiter;
    localparam int CD        = 2;
    localparam int FB        = 64;
    localparam int FRAME_LEN = 1 + 2 * CD * (FB + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic segclk, segclr, segdt, segen;

    seg_display_arbiter_if #(.FRAME_BITS(FB)) bus ();

    seg_display_arbiter #(.CLK_DIV(CD), .FRAME_BITS(FB)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.slave),
        .SEGCLK (segclk),
        .SEGCLR (segclr),
        .SEGDT  (segdt),
        .SEGEN  (segen)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model state: one buffer/pending flag per channel, arbitration when free.
    logic [FB-1:0] m_buf0, m_buf1;
    logic          m_pend0, m_pend1, m_ack0, m_ack1, m_busy, m_src;
    int            m_edge, m_free, m_busy_end;
    logic [64:0]   exp_q[$];
    logic [64:0]   got_q[$];

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_pend0 = 1'b0; m_pend1 = 1'b0; m_ack0 = 1'b0; m_ack1 = 1'b0;
                m_busy = 1'b0; m_src = 1'b0; m_edge = 0; m_free = 2 * CD + 1;
                m_busy_end = -1; m_buf0 = '0; m_buf1 = '0;
                exp_q.delete();
            end else begin
                m_edge++;
                m_ack0 = 1'b0;
                m_ack1 = 1'b0;
                if (m_busy && m_edge == m_busy_end) m_busy = 1'b0;
                if (m_edge >= m_free && (m_pend1 || (m_pend0 && !bus.hold1))) begin
                    if (m_pend1) begin
                        exp_q.push_back({1'b1, m_buf1}); m_src = 1'b1; m_ack1 = 1'b1; m_pend1 = 1'b0;
                    end else begin
                        exp_q.push_back({1'b0, m_buf0}); m_src = 1'b0; m_ack0 = 1'b1; m_pend0 = 1'b0;
                    end
                    m_busy = 1'b1;
                    m_busy_end = m_edge + FRAME_LEN;
                    m_free = m_edge + FRAME_LEN + 1;
                end
                if (bus.req0) begin m_buf0 = bus.data0; m_pend0 = 1'b1; end
                if (bus.req1) begin m_buf1 = bus.data1; m_pend1 = 1'b1; end
            end
        end
    end

    // Monitor: per-cycle handshake checks and frame decoding on SEGCLK rising edges.
    logic [FB-1:0] mon_shift;
    logic          mon_prev_clk;
    int            mon_bits, busy_len;
    logic [64:0]   exp_frame;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon_prev_clk = 1'b0; mon_bits = 0; mon_shift = '0; busy_len = 0;
            end else begin
                check("ack0", {64'd0, bus.ack0}, {64'd0, m_ack0});
                check("ack1", {64'd0, bus.ack1}, {64'd0, m_ack1});
                check("busy", {64'd0, bus.busy}, {64'd0, m_busy});
                check("active_src", {64'd0, bus.active_src}, {64'd0, m_src});
                if (segclk && !mon_prev_clk) begin
                    mon_shift = {mon_shift[FB-2:0], segdt};
                    mon_bits++;
                end
                mon_prev_clk = segclk;
                if (bus.busy) busy_len++;
                else if (busy_len != 0) begin
                    check("busy_length", 65'(busy_len), 65'(FRAME_LEN));
                    busy_len = 0;
                end
                if (bus.frame_done) begin
                    check("rising_edges", 65'(mon_bits), 65'(FB));
                    got_q.push_back({bus.active_src, mon_shift});
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", {bus.active_src, mon_shift}, 65'd0);
                    end else begin
                        exp_frame = exp_q.pop_front();
                        check("model_frame", {bus.active_src, mon_shift}, exp_frame);
                    end
                    mon_bits = 0;
                end
            end
        end
    end

    task automatic drain(input int budget);
        bit done = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.hold1 = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk); #1;
            if (!m_pend0 && !m_pend1 && !bus.busy) done = 1'b1;
        end
        if (!done) check("drain_timeout", 65'd0, 65'd1);
    endtask

    task automatic pulse(input logic r0, input logic [FB-1:0] d0, input logic r1, input logic [FB-1:0] d1);
        @(negedge clk);
        bus.req0 = r0; bus.data0 = d0; bus.req1 = r1; bus.data1 = d1;
        @(negedge clk);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
    endtask

    typedef struct {
        logic          r0;
        logic          r1;
        logic [FB-1:0] d0;
        logic [FB-1:0] d1;
        int            n;
        logic [64:0]   fa;
        logic [64:0]   fb;
    } vec_t;

    vec_t vecs[5];
    int   lat;
    bit   seen;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 64'hC0F9_A4B0_9992_82F8, 64'h0, 1, {1'b0, 64'hC0F9_A4B0_9992_82F8}, 65'd0};
        vecs[1] = '{1'b0, 1'b1, 64'h0, 64'h8888_C7C0_88A1_FF86, 1, {1'b1, 64'h8888_C7C0_88A1_FF86}, 65'd0};
        vecs[2] = '{1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 2,
                    {1'b1, 64'hFEDC_BA98_7654_3210}, {1'b0, 64'h0123_4567_89AB_CDEF}};
        vecs[3] = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF}, 65'd0};
        vecs[4] = '{1'b0, 1'b1, 64'h0, 64'h8000_0000_0000_0001, 1, {1'b1, 64'h8000_0000_0000_0001}, 65'd0};

        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.hold1 = 1'b0;
        bus.data0 = '0; bus.data1 = '0;

        // Reset values, then the INIT clear window.
        repeat (3) @(posedge clk);
        #1;
        check("rst_segclr", {64'd0, segclr}, 65'd0);
        check("rst_segen", {64'd0, segen}, 65'd0);
        check("rst_segclk", {64'd0, segclk}, 65'd0);
        check("rst_busy", {64'd0, bus.busy}, 65'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            check("init_segclr", {64'd0, segclr}, (k >= 2 * CD) ? 65'd1 : 65'd0);
            check("init_segen", {64'd0, segen}, 65'd1);
            check("init_segclk", {64'd0, segclk}, 65'd0);
            check("init_busy", {64'd0, bus.busy}, 65'd0);
        end

        // Table-driven single and contended frames.
        for (int v = 0; v < 5; v++) begin
            drain(2000);
            got_q.delete();
            pulse(vecs[v].r0, vecs[v].d0, vecs[v].r1, vecs[v].d1);
            drain(2000);
            check("vec_frame_count", 65'(got_q.size()), 65'(vecs[v].n));
            if (got_q.size() >= 1) check("vec_frame_a", got_q[0], vecs[v].fa);
            if (got_q.size() >= 2) check("vec_frame_b", got_q[1], vecs[v].fb);
        end

        // Overwrite while channel 1 is in flight: only the latest channel-0 frame goes out.
        got_q.delete();
        pulse(1'b0, 64'h0, 1'b1, 64'h1111_2222_3333_4444);
        repeat (10) @(negedge clk);
        pulse(1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 64'h0);
        repeat (5) @(negedge clk);
        pulse(1'b1, 64'hBBBB_0000_BBBB_0000, 1'b0, 64'h0);
        drain(2000);
        check("ovw_count", 65'(got_q.size()), 65'd2);
        if (got_q.size() >= 2) begin
            check("ovw_first", got_q[0], {1'b1, 64'h1111_2222_3333_4444});
            check("ovw_second", got_q[1], {1'b0, 64'hBBBB_0000_BBBB_0000});
        end

        // Hold locks out channel 0 until released.
        got_q.delete();
        @(negedge clk);
        bus.hold1 = 1'b1;
        pulse(1'b1, 64'h5A5A_A5A5_0F0F_F0F0, 1'b0, 64'h0);
        repeat (20) @(negedge clk);
        check("hold_no_busy", {64'd0, bus.busy}, 65'd0);
        bus.hold1 = 1'b0;
        lat = 0; seen = 1'b0;
        for (int k = 1; k <= 4 && !seen; k++) begin
            @(negedge clk);
            if (bus.busy) begin seen = 1'b1; lat = k; end
        end
        check("hold_release_start", {64'd0, seen && lat <= 2}, 65'd1);
        drain(2000);
        check("hold_frame", (got_q.size() == 1) ? got_q[0] : 65'd0, {1'b0, 64'h5A5A_A5A5_0F0F_F0F0});

        // Randomised traffic checked by the reference model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            bus.req0  = ($urandom_range(0, 39) == 0);
            bus.data0 = {$urandom, $urandom};
            bus.req1  = ($urandom_range(0, 79) == 0);
            bus.data1 = {$urandom, $urandom};
            if ($urandom_range(0, 99) == 0) bus.hold1 = ~bus.hold1;
        end
        drain(3000);
        check("random_exp_empty", 65'(exp_q.size()), 65'd0);

        // Reset at bit 20 aborts the frame and drops the pending request.
        got_q.delete();
        pulse(1'b1, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 64'h7777_7777_7777_7777);
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk); #2;
            if (mon_bits >= 20) seen = 1'b1;
        end
        check("reach_bit20", {64'd0, seen}, 65'd1);
        rst = 1'b0;
        #1;
        check("abort_segclk", {64'd0, segclk}, 65'd0);
        check("abort_segdt", {64'd0, segdt}, 65'd0);
        check("abort_busy", {64'd0, bus.busy}, 65'd0);
        check("abort_segclr", {64'd0, segclr}, 65'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (600) @(negedge clk);
        check("abort_no_frame", 65'(got_q.size()), 65'd0);
        check("abort_idle", {64'd0, bus.busy}, 65'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
